master_rx_port: RTL and testbench

- Parametrised successor to the master-side serial read-data receiver.
- Deserialises read data driven by a slave over a LANES-bit-wide serial link into DATA_WIDTH-bit words, for single reads and bursts of up to 2^BURST_LEN-1 words.
- Completed words go into an internal FIFO and drain to the master core over a valid/ready interface.
- master_ready back-pressures the slave whenever the FIFO is full.

---
 rtl/master_rx_pkg.sv | 20 ++
 rtl/rx_word_fifo.sv | 64 ++++++
 rtl/master_rx_port.sv | 180 ++++++++++++++++++
 tb/tb_master_rx_port.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/master_rx_pkg.sv
// Shared command codes and receiver state encoding for master_rx_port.
// Optional parity beat support is enabled by defining MASTER_RX_PARITY_EN.
package master_rx_pkg;

    localparam logic [1:0] INSTR_NOP   = 2'b00;
    localparam logic [1:0] INSTR_WRITE = 2'b01;
    localparam logic [1:0] INSTR_RSVD  = 2'b10;
    localparam logic [1:0] INSTR_READ  = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        DONE    = 2'd2
`ifdef MASTER_RX_PARITY_EN
        ,
        PARITY  = 2'd3
`endif
    } rx_state_t;

endpackage

// File: rtl/rx_word_fifo.sv
// First-word-fall-through word FIFO with asynchronous active-low reset.
// The head word is read straight from storage; when empty, the last popped word is held.
module rx_word_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            i_push,
    input  logic [DATA_WIDTH-1:0]           i_pushData,
    input  logic                            i_pop,
    output logic [DATA_WIDTH-1:0]           o_data,
    output logic                            o_full,
    output logic                            o_empty,
    output logic [$clog2(FIFO_DEPTH):0]     o_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wrPtr;
    logic [PTR_W-1:0]      r_rdPtr;
    logic [CNT_W-1:0]      r_count;
    logic [DATA_WIDTH-1:0] r_lastData;
    logic                  w_doPush;
    logic                  w_doPop;

    assign o_full   = (r_count == CNT_W'(FIFO_DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_data   = o_empty ? r_lastData : r_mem[r_rdPtr];

    // A pop on the same edge frees the slot, so a push into a full FIFO is still legal then.
    assign w_doPop  = i_pop && !o_empty;
    assign w_doPush = i_push && (!o_full || w_doPop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_lastData <= '0;
        end else begin
            if (w_doPush) begin
                r_mem[r_wrPtr] <= i_pushData;
                r_wrPtr        <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_lastData <= r_mem[r_rdPtr];
                r_rdPtr    <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/master_rx_port.sv
// Master-side serial read-data receiver: deserialises LANES-wide beats into words and queues them.
// Defining MASTER_RX_PARITY_EN adds a per-word even-parity beat and the parity_err output.
module master_rx_port
    import master_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 1,
    parameter int BURST_LEN  = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tx_done,
    input  logic [1:0]            instruction,
    input  logic [BURST_LEN-1:0]  burst_num,
    input  logic [LANES-1:0]      rx_data,
    input  logic                  slave_valid,
    output logic                  master_ready,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  new_rx,
    output logic                  rx_done,
    output logic                  busy
`ifdef MASTER_RX_PARITY_EN
    ,
    output logic                  parity_err
`endif
);

    localparam int BEATS  = DATA_WIDTH / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    rx_state_t             r_state;
    rx_state_t             w_nextState;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_assembled;
    logic [DATA_WIDTH-1:0] w_pushData;
    logic [BEAT_W-1:0]     r_beat;
    logic [BURST_LEN-1:0]  r_wordCnt;
    logic [BURST_LEN-1:0]  r_words;
    logic                  r_newRx;
    logic                  w_start;
    logic                  w_receiving;
    logic                  w_accept;
    logic                  w_lastBeat;
    logic                  w_lastWord;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_fifoFull;
    logic                  w_fifoEmpty;
    logic [CNT_W-1:0]      w_fifoCount;
    logic                  w_unused;

    assign w_start    = (r_state == IDLE) && tx_done && (instruction == INSTR_READ);
`ifdef MASTER_RX_PARITY_EN
    assign w_receiving = (r_state == RECEIVE) || (r_state == PARITY);
`else
    assign w_receiving = (r_state == RECEIVE);
`endif
    assign master_ready = w_receiving && !w_fifoFull;
    assign w_accept     = slave_valid && master_ready;
    assign w_lastBeat   = (r_beat == LAST_BEAT);
    assign w_lastWord   = (r_wordCnt == (r_words - 1'b1));
    assign w_pop        = data_ready && !w_fifoEmpty;

    assign busy       = (r_state != IDLE);
    assign rx_done    = (r_state == DONE);
    assign new_rx     = r_newRx;
    assign data_valid = !w_fifoEmpty;

    always_comb begin
        w_assembled = r_shift;
        w_assembled[int'(r_beat) * LANES +: LANES] = rx_data;
    end

`ifdef MASTER_RX_PARITY_EN
    logic r_parityErr;
    logic w_parityBad;

    // The word is complete in r_shift by the time its parity beat arrives.
    assign w_push      = (r_state == PARITY) && w_accept;
    assign w_pushData  = r_shift;
    assign w_parityBad = (^r_shift) ^ rx_data[0];
    assign parity_err  = r_parityErr;
    assign w_unused    = ^{w_fifoCount, rx_data};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_parityErr <= 1'b0;
        end else if (w_start) begin
            r_parityErr <= 1'b0;
        end else if (w_push && w_parityBad) begin
            r_parityErr <= 1'b1;
        end
    end
`else
    assign w_push     = (r_state == RECEIVE) && w_accept && w_lastBeat;
    assign w_pushData = w_assembled;
    assign w_unused   = ^w_fifoCount;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) w_nextState = RECEIVE;
            end
            RECEIVE: begin
                if (w_accept && w_lastBeat) begin
`ifdef MASTER_RX_PARITY_EN
                    w_nextState = PARITY;
`else
                    if (w_lastWord) w_nextState = DONE;
`endif
                end
            end
`ifdef MASTER_RX_PARITY_EN
            PARITY: begin
                if (w_accept) w_nextState = w_lastWord ? DONE : RECEIVE;
            end
`endif
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Word count is latched at start so burst_num may change mid-transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift   <= '0;
            r_beat    <= '0;
            r_wordCnt <= '0;
            r_words   <= '0;
            r_newRx   <= 1'b0;
        end else begin
            r_newRx <= w_push;
            if (w_start) begin
                r_words   <= (burst_num == '0) ? BURST_LEN'(1) : burst_num;
                r_wordCnt <= '0;
                r_beat    <= '0;
                r_shift   <= '0;
            end else begin
                if ((r_state == RECEIVE) && w_accept) begin
                    r_shift <= w_assembled;
                    r_beat  <= w_lastBeat ? '0 : r_beat + 1'b1;
                end
                if (w_push) begin
                    r_wordCnt <= r_wordCnt + 1'b1;
                end
            end
        end
    end

    rx_word_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_push),
        .i_pushData (w_pushData),
        .i_pop      (w_pop),
        .o_data     (data),
        .o_full     (w_fifoFull),
        .o_empty    (w_fifoEmpty),
        .o_count    (w_fifoCount)
    );

endmodule

// File: tb/tb_master_rx_port.sv
// Self-checking bench for master_rx_port: single-lane instance (depth 2) and four-lane instance.
// Works with or without MASTER_RX_PARITY_EN defined.
module tb_master_rx_port;

    localparam logic [1:0] READ = 2'b11;
    localparam int A_DEPTH = 2;
`ifdef MASTER_RX_PARITY_EN
    localparam int BPW = 9;
`else
    localparam int BPW = 8;
`endif

    logic clk = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    // Instance A: LANES=1, FIFO_DEPTH=2
    logic        aTxDone = 0;
    logic [1:0]  aInstr = 0;
    logic [11:0] aBurst = 0;
    logic        aRx = 0;
    logic        aSv = 0;
    logic        aReady;
    logic [7:0]  aData;
    logic        aValid;
    logic        aDr = 0;
    logic        aNewRx, aRxDone, aBusy;
`ifdef MASTER_RX_PARITY_EN
    logic        aPerr;
`endif

    // Instance B: LANES=4, FIFO_DEPTH=4
    logic        bTxDone = 0;
    logic [1:0]  bInstr = 0;
    logic [11:0] bBurst = 0;
    logic [3:0]  bRx = 0;
    logic        bSv = 0;
    logic        bReady;
    logic [7:0]  bData;
    logic        bValid;
    logic        bDr = 0;
    logic        bNewRx, bRxDone, bBusy;
`ifdef MASTER_RX_PARITY_EN
    logic        bPerr;
`endif

    master_rx_port #(.DATA_WIDTH(8), .LANES(1), .BURST_LEN(12), .FIFO_DEPTH(A_DEPTH)) dutA (
        .clk(clk), .reset(rstN), .tx_done(aTxDone), .instruction(aInstr), .burst_num(aBurst),
        .rx_data(aRx), .slave_valid(aSv), .master_ready(aReady), .data(aData),
        .data_valid(aValid), .data_ready(aDr), .new_rx(aNewRx), .rx_done(aRxDone), .busy(aBusy)
`ifdef MASTER_RX_PARITY_EN
        , .parity_err(aPerr)
`endif
    );

    master_rx_port #(.DATA_WIDTH(8), .LANES(4), .BURST_LEN(12), .FIFO_DEPTH(4)) dutB (
        .clk(clk), .reset(rstN), .tx_done(bTxDone), .instruction(bInstr), .burst_num(bBurst),
        .rx_data(bRx), .slave_valid(bSv), .master_ready(bReady), .data(bData),
        .data_valid(bValid), .data_ready(bDr), .new_rx(bNewRx), .rx_done(bRxDone), .busy(bBusy)
`ifdef MASTER_RX_PARITY_EN
        , .parity_err(bPerr)
`endif
    );

    int errors = 0;
    int checks = 0;
    int stallCount = 0;
    logic [7:0] txWords[$];
    logic [7:0] poppedQ[$];

    typedef struct {
        logic [1:0]  instr;
        logic [11:0] burst;
        logic [23:0] payload;
        int          validPct;
        int          readyPct;
        int          expWords;
        logic [23:0] expData;
    } vec_t;

    vec_t vecs[6];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drives one transaction on instance A; the slave serialises txWords LSB-first
    // and the model tracks pushed/popped words to predict every handshake output.
    task automatic applyStimulus(input logic [1:0] instr, input logic [11:0] burst,
                                 input int validPct, input int readyPct,
                                 input int holdCycles, input bit badParity);
        int words, total, beatIdx, completed, popped, cyc, occ, wi, bi;
        bit justPushed, lastPushed, finishing;
        logic [7:0] w;
        poppedQ.delete();
        aTxDone = 1; aInstr = instr; aBurst = burst;
        tick();
        aTxDone = 0; aInstr = 2'b00; aBurst = '0;
        if (instr != READ) begin
            checkOutput("ignoredBusy", aBusy, 0);
            checkOutput("ignoredReady", aReady, 0);
            return;
        end
        checkOutput("startBusy", aBusy, 1);
`ifdef MASTER_RX_PARITY_EN
        checkOutput("parityClearOnStart", aPerr, 0);
`endif
        words = (burst == 0) ? 1 : int'(burst);
        total = words * BPW;
        beatIdx = 0; completed = 0; popped = 0; cyc = 0;
        justPushed = 0; lastPushed = 0; finishing = 0;
        while (!finishing) begin
            if (cyc >= 2000) begin
                checks++; errors++;
                $display("[TB] FAIL timeout: got no completion, expected rx_done within 2000 cycles");
                break;
            end
            checkOutput("newRx", aNewRx, justPushed);
            checkOutput("rxDone", aRxDone, lastPushed);
            occ = completed - popped;
            checkOutput("dataValid", aValid, occ > 0);
            if (beatIdx < total) checkOutput("masterReady", aReady, occ < A_DEPTH);
            else checkOutput("readyAfterLast", aReady, 0);
            if (lastPushed) begin
                checkOutput("busyInDone", aBusy, 1);
                finishing = 1;
            end
            wi = beatIdx / BPW;
            bi = beatIdx % BPW;
            w = (wi < words) ? txWords[wi] : 8'h00;
            aSv = (beatIdx < total) && ($urandom_range(99) < validPct);
            aRx = (bi < 8) ? w[bi] : ((^w) ^ (badParity && wi == 0));
            aDr = (cyc >= holdCycles) && ($urandom_range(99) < readyPct);
            if (aValid && aDr) begin
                if (popped < completed) checkOutput("popData", aData, txWords[popped]);
                else checkOutput("popWhileEmpty", 1, 0);
                poppedQ.push_back(aData);
                popped++;
            end
            justPushed = 0; lastPushed = 0;
            if (aSv && !aReady) stallCount++;
            if (aSv && aReady) begin
                beatIdx++;
                if (beatIdx % BPW == 0) begin
                    completed++;
                    justPushed = 1;
                    lastPushed = (completed == words);
                end
            end
            tick();
            cyc++;
        end
        aSv = 0; aDr = 0;
        checkOutput("busyIdle", aBusy, 0);
        for (int i = 0; i < 2 * A_DEPTH + 2; i++) begin
            if (!aValid) break;
            aDr = 1;
            if (popped < completed) checkOutput("drainData", aData, txWords[popped]);
            else checkOutput("drainExtra", 1, 0);
            poppedQ.push_back(aData);
            popped++;
            tick();
        end
        aDr = 0;
        checkOutput("allDelivered", popped, words);
        checkOutput("emptyAfter", aValid, 0);
`ifdef MASTER_RX_PARITY_EN
        checkOutput("parityErr", aPerr, badParity);
`endif
    endtask

    initial begin
        logic [23:0] got;
        int n;
        logic [11:0] burst;

        vecs[0] = '{READ,  12'd0, 24'h0000D6, 100, 100, 1, 24'h0000D6};
        vecs[1] = '{READ,  12'd3, 24'hDED45E, 100, 100, 3, 24'hDED45E};
        vecs[2] = '{2'b01, 12'd0, 24'h0000AA, 100, 100, 0, 24'h000000};
        vecs[3] = '{READ,  12'd2, 24'h00FF00,  60,  50, 2, 24'h00FF00};
        vecs[4] = '{2'b10, 12'd5, 24'h123456, 100, 100, 0, 24'h000000};
        vecs[5] = '{READ,  12'd1, 24'h0000A5, 100,   0, 1, 24'h0000A5};

        // Reset state
        tick();
        tick();
        checkOutput("rstReadyA", aReady, 0);
        checkOutput("rstDataA", aData, 0);
        checkOutput("rstValidA", aValid, 0);
        checkOutput("rstNewRxA", aNewRx, 0);
        checkOutput("rstRxDoneA", aRxDone, 0);
        checkOutput("rstBusyA", aBusy, 0);
        checkOutput("rstBusyB", bBusy, 0);
        checkOutput("rstValidB", bValid, 0);
        rstN = 1;
        tick();

        $display("[TB] table vectors");
        for (int v = 0; v < 6; v++) begin
            txWords.delete();
            for (int k = 0; k < 3; k++) txWords.push_back(vecs[v].payload[8*k +: 8]);
            applyStimulus(vecs[v].instr, vecs[v].burst, vecs[v].validPct, vecs[v].readyPct, 0, 0);
            got = '0;
            for (int k = 0; k < poppedQ.size() && k < 3; k++) got[8*k +: 8] = poppedQ[k];
            checkOutput("vecWords", poppedQ.size(), vecs[v].expWords);
            checkOutput("vecData", got, vecs[v].expData);
        end

        $display("[TB] back-pressure burst of 4");
        txWords = '{8'h11, 8'h22, 8'h33, 8'h44};
        stallCount = 0;
        applyStimulus(READ, 12'd4, 100, 100, 40, 0);
        checkOutput("stalledWhenFull", stallCount > 0, 1);

        $display("[TB] reset mid-burst");
        aTxDone = 1; aInstr = READ; aBurst = 12'd3;
        tick();
        aTxDone = 0; aInstr = 0; aBurst = 0;
        for (int i = 0; i < 12; i++) begin
            aSv = 1; aRx = 1'($urandom);
            tick();
        end
        aSv = 0;
        checkOutput("midBurstBusy", aBusy, 1);
        rstN = 0;
        #1;
        checkOutput("midRstReady", aReady, 0);
        checkOutput("midRstData", aData, 0);
        checkOutput("midRstValid", aValid, 0);
        checkOutput("midRstNewRx", aNewRx, 0);
        checkOutput("midRstRxDone", aRxDone, 0);
        checkOutput("midRstBusy", aBusy, 0);
        @(negedge clk);
        rstN = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("postRstRxDone", aRxDone, 0);
            checkOutput("postRstValid", aValid, 0);
        end
        txWords = '{8'h5A};
        applyStimulus(READ, 12'd0, 100, 100, 0, 0);

`ifdef MASTER_RX_PARITY_EN
        $display("[TB] parity");
        txWords = '{8'h01};
        applyStimulus(READ, 12'd0, 100, 100, 0, 0);
        applyStimulus(READ, 12'd0, 100, 100, 0, 1);
`endif

        $display("[TB] four-lane stall");
        bTxDone = 1; bInstr = READ; bBurst = 0;
        tick();
        bTxDone = 0; bInstr = 0;
        checkOutput("bStartBusy", bBusy, 1);
        checkOutput("bStartReady", bReady, 1);
        bSv = 1; bRx = 4'hA;
        tick();
        bSv = 0; bRx = 4'hF;
        for (int i = 0; i < 2; i++) begin
            checkOutput("bGapReady", bReady, 1);
            checkOutput("bGapValid", bValid, 0);
            checkOutput("bGapNewRx", bNewRx, 0);
            checkOutput("bGapBusy", bBusy, 1);
            tick();
        end
        bSv = 1; bRx = 4'h3;
        tick();
`ifdef MASTER_RX_PARITY_EN
        checkOutput("bBeforeParity", bValid, 0);
        bSv = 1; bRx = 4'b1110;
        tick();
`endif
        bSv = 0;
        checkOutput("bValid", bValid, 1);
        checkOutput("bData", bData, 8'h3A);
        checkOutput("bNewRx", bNewRx, 1);
        checkOutput("bRxDone", bRxDone, 1);
        bDr = 1;
        tick();
        bDr = 0;
        checkOutput("bBusyIdle", bBusy, 0);
        checkOutput("bEmpty", bValid, 0);
        checkOutput("bDataHeld", bData, 8'h3A);
`ifdef MASTER_RX_PARITY_EN
        checkOutput("bParity", bPerr, 0);
`endif

        $display("[TB] random transactions");
        for (int t = 0; t < 12; t++) begin
            burst = 12'($urandom_range(0, 5));
            n = (burst == 0) ? 1 : int'(burst);
            txWords.delete();
            for (int k = 0; k < n; k++) txWords.push_back(8'($urandom));
            applyStimulus(READ, burst, int'($urandom_range(40, 100)), int'($urandom_range(20, 100)), 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
